// File: rtl/uart.sv
// uart: memory-mapped 8N1 serial port (TX holding + shift register, RX one-byte buffer with status flags).
// Latency: DATA write -> txd falls one cycle later when idle; rx_valid rises ~DIV/2 + 9*DIV + 2 cycles after the start edge.
// Backpressure: a DATA write while tx_ready=0 is dropped; a good RX byte arriving while rx_valid=1 is dropped and flags overrun.
//
// Ports:
//   clk        system clock (single domain)
//   rst        asynchronous active-low reset
//   addr       register select: 00 DATA, 01 STATUS, 10 CTRL, 11 DIVISOR
//   we         one-cycle write strobe
//   DEV_WD     write data
//   DEVUart_RD combinational read data for the selected register
//   IRQ        level interrupt: (tx_irq_en & tx_ready) | (rx_irq_en & rx_valid)
//   rxd        asynchronous serial input, idles high
//   txd        registered serial output, idles high
module uart #(
  parameter int DIV_DEFAULT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:2]  addr,
  input  logic        we,
  input  logic [31:0] DEV_WD,
  output logic [31:0] DEVUart_RD,
  output logic        IRQ,
  input  logic        rxd,
  output logic        txd
);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [15:0] DIV_RST = 16'(DIV_DEFAULT);

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  logic        wr_data, wr_stat, wr_ctrl, wr_div;
  logic [15:0] div_wr_val;
  logic        unused_wd;

  assign wr_data    = we && (addr == 2'b00);
  assign wr_stat    = we && (addr == 2'b01);
  assign wr_ctrl    = we && (addr == 2'b10);
  assign wr_div     = we && (addr == 2'b11);
  // Divisors below 4 would leave the RX half-bit wait at zero or one cycle.
  assign div_wr_val = (DEV_WD[15:0] < 16'd4) ? 16'd4 : DEV_WD[15:0];
  assign unused_wd  = ^DEV_WD[31:16];

  logic [15:0] div_reg;
  logic        tx_irq_en, rx_irq_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg   <= DIV_RST;
      tx_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
    end else begin
      if (wr_div) div_reg <= div_wr_val;
      if (wr_ctrl) begin
        tx_irq_en <= DEV_WD[0];
        rx_irq_en <= DEV_WD[1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_t   tx_state, tx_state_nxt;
  logic [7:0]  tx_hold, tx_shift;
  logic        tx_full;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic        tx_load, txd_nxt, tx_cnt_zero;
  logic        tx_ready, tx_idle;

  assign tx_cnt_zero = (tx_cnt == 16'd0);
  assign tx_ready    = !tx_full;
  assign tx_idle     = (tx_state == TX_IDLE) && tx_ready;

  always_comb begin
    tx_state_nxt = tx_state;
    tx_load      = 1'b0;
    txd_nxt      = txd;
    case (tx_state)
      TX_IDLE: begin
        if (tx_full) begin
          tx_state_nxt = TX_START;
          tx_load      = 1'b1;
          txd_nxt      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_zero) begin
          tx_state_nxt = TX_DATA;
          txd_nxt      = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_zero) begin
          if (tx_bit == 3'd7) begin
            tx_state_nxt = TX_STOP;
            txd_nxt      = 1'b1;
          end else begin
            // Next bit is the one the shift below brings to position 0.
            txd_nxt = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_zero) begin
          if (tx_full) begin
            tx_state_nxt = TX_START;
            tx_load      = 1'b1;
            txd_nxt      = 1'b0;
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      txd      <= txd_nxt;
    end
  end

  // Holding register: a write on the cycle it empties sees tx_full=1 and is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_full <= 1'b0;
      tx_hold <= 8'd0;
    end else if (tx_load) begin
      tx_full <= 1'b0;
    end else if (wr_data && !tx_full) begin
      tx_full <= 1'b1;
      tx_hold <= DEV_WD[7:0];
    end
  end

  // The divisor is latched at frame start so mid-frame writes only affect later frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt   <= 16'd0;
      tx_div   <= DIV_RST;
      tx_shift <= 8'd0;
      tx_bit   <= 3'd0;
    end else if (tx_load) begin
      tx_cnt   <= div_reg - 16'd1;
      tx_div   <= div_reg;
      tx_shift <= tx_hold;
      tx_bit   <= 3'd0;
    end else if (tx_state != TX_IDLE) begin
      if (tx_cnt_zero) begin
        tx_cnt <= tx_div - 16'd1;
        if (tx_state == TX_DATA) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt - 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic        rx_meta, rx_sync;
  rx_state_t   rx_state, rx_state_nxt;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift, rx_data;
  logic        rx_arm, rx_cnt_zero;
  logic        rx_valid, overrun, frame_err;
  logic        stop_hit, rx_good, rx_bad, clr_valid, rx_store;

  // Synchroniser flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
    end
  end

  assign rx_cnt_zero = (rx_cnt == 16'd0);

  always_comb begin
    rx_state_nxt = rx_state;
    rx_arm       = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_nxt = RX_START;
          rx_arm       = 1'b1;
        end
      end
      RX_START: begin
        // Mid-start-bit re-sample: still high means the low was a glitch.
        if (rx_cnt_zero) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_cnt_zero && (rx_bit == 3'd7)) rx_state_nxt = RX_STOP;
      end
      RX_STOP: begin
        if (rx_cnt_zero) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt   <= 16'd0;
      rx_div   <= DIV_RST;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else if (rx_arm) begin
      rx_div <= div_reg;
      rx_cnt <= (div_reg >> 1) - 16'd1;
      rx_bit <= 3'd0;
    end else if (rx_state != RX_IDLE) begin
      if (rx_cnt_zero) begin
        rx_cnt <= rx_div - 16'd1;
        if (rx_state == RX_DATA) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
        end
      end else begin
        rx_cnt <= rx_cnt - 16'd1;
      end
    end
  end

  assign stop_hit  = (rx_state == RX_STOP) && rx_cnt_zero;
  assign rx_good   = stop_hit && rx_sync;
  assign rx_bad    = stop_hit && !rx_sync;
  assign clr_valid = wr_stat && DEV_WD[2];
  // A clear landing with a fresh byte frees the buffer for that byte.
  assign rx_store  = rx_good && (!rx_valid || clr_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_store) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (clr_valid) begin
        rx_valid <= 1'b0;
      end

      if (rx_good && !rx_store)           overrun <= 1'b1;
      else if (wr_stat && DEV_WD[3])      overrun <= 1'b0;

      if (rx_bad)                         frame_err <= 1'b1;
      else if (wr_stat && DEV_WD[4])      frame_err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and interrupt
  // ---------------------------------------------------------------------------
  always_comb begin
    DEVUart_RD = 32'd0;
    case (addr)
      2'b00:   DEVUart_RD = {24'd0, rx_data};
      2'b01:   DEVUart_RD = {27'd0, frame_err, overrun, rx_valid, tx_idle, tx_ready};
      2'b10:   DEVUart_RD = {30'd0, rx_irq_en, tx_irq_en};
      default: DEVUart_RD = {16'd0, div_reg};
    endcase
  end

  assign IRQ = (tx_irq_en && tx_ready) || (rx_irq_en && rx_valid);

endmodule

// File: tb/tb_uart.sv
module tb_uart;

  localparam int DIV_DEFAULT = 434;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] dev_wd;
  logic [31:0] rd_data;
  logic        irq;
  logic        rxd;
  logic        txd;

  always #5 clk = ~clk;

  uart #(.DIV_DEFAULT(DIV_DEFAULT)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .we        (we),
    .DEV_WD    (dev_wd),
    .DEVUart_RD(rd_data),
    .IRQ       (irq),
    .rxd       (rxd),
    .txd       (txd)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model of the receive side and control register.
  logic       m_valid, m_ovr, m_fe;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;

  // Valid only while the transmitter is idle (tx_ready = tx_idle = 1).
  function automatic logic [31:0] m_status();
    return {27'd0, m_fe, m_ovr, m_valid, 1'b1, 1'b1};
  endfunction

  function automatic logic [31:0] m_irq();
    return {31'd0, m_ctrl[0] | (m_ctrl[1] & m_valid)};
  endfunction

  // 8N1 frame: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Stimulus runs one cycle at a time, 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr   = a;
    dev_wd = d;
    we     = 1'b1;
    tick(1);
    we     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd_data;
  endtask

  // txd is recorded on falling edges while rec is set.
  logic rec = 1'b0;
  logic txq[$];
  always @(negedge clk) if (rec) txq.push_back(txd);

  // Three writes: b1 starts a frame, b2 is accepted back-to-back, b3 arrives while full and must vanish.
  // The divisor changes mid-frame-1, so frame 1 keeps div1 and frame 2 uses div2.
  task automatic tx_test(input int it, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input int div1, input int div2);
    int idx, len, cnt, rem;
    logic [7:0]  fb;
    logic [31:0] v;
    wr(2'b11, div1);
    txq.delete();
    rec = 1'b1;
    wr(2'b00, {24'd0, b1});
    tick(1);
    wr(2'b00, {24'd0, b2});
    wr(2'b00, {24'd0, b3});
    tick(40);
    wr(2'b11, div2);
    tick(10 * div1 + 10 * div2);
    rec = 1'b0;

    cnt = 0;
    for (int i = 0; i < 2; i++) if (txq[i] === 1'b1) cnt++;
    check($sformatf("tx%0d lead idle", it), cnt, 2);
    idx = 2;
    for (int f = 0; f < 2; f++) begin
      fb  = (f == 0) ? b1 : b2;
      len = (f == 0) ? div1 : div2;
      for (int k = 0; k < 10; k++) begin
        cnt = 0;
        for (int s = 0; s < len; s++)
          if (idx + s < txq.size() && txq[idx + s] === frame_bit(fb, k)) cnt++;
        check($sformatf("tx%0d frame%0d bit%0d", it, f, k), cnt, len);
        idx += len;
      end
    end
    rem = txq.size() - idx;
    cnt = 0;
    for (int i = idx; i < txq.size(); i++) if (txq[i] === 1'b1) cnt++;
    check($sformatf("tx%0d tail idle", it), cnt, rem);
    check($sformatf("tx%0d tail long", it), (rem >= 20) ? 1 : 0, 1);
    rd(2'b01, v);
    check($sformatf("tx%0d status after", it), v, 32'h3);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input int div);
    rxd = 1'b0;
    tick(div);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      tick(div);
    end
    rxd = stop;
    tick(div);
    rxd = 1'b1;
    tick(20);
  endtask

  task automatic rx_byte(input string tag, input logic [7:0] b, input logic stop);
    logic [31:0] v;
    rx_send(b, stop, 16);
    if (!stop)         m_fe = 1'b1;
    else if (!m_valid) begin m_data = b; m_valid = 1'b1; end
    else               m_ovr = 1'b1;
    rd(2'b01, v);
    check({tag, " status"}, v, m_status());
    rd(2'b00, v);
    check({tag, " data"}, v, {24'd0, m_data});
    check({tag, " irq"}, {31'd0, irq}, m_irq());
  endtask

  task automatic w1c(input string tag, input logic [31:0] d);
    logic [31:0] v;
    wr(2'b01, d);
    if (d[2]) m_valid = 1'b0;
    if (d[3]) m_ovr   = 1'b0;
    if (d[4]) m_fe    = 1'b0;
    rd(2'b01, v);
    check({tag, " status"}, v, m_status());
    check({tag, " irq"}, {31'd0, irq}, m_irq());
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] dv;
    rst = 1'b0; we = 1'b0; addr = 2'b00; dev_wd = 32'd0; rxd = 1'b1;
    m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; m_data = 8'd0; m_ctrl = 2'd0;

    // Reset state
    tick(3);
    check("rst txd", {31'd0, txd}, 32'd1);
    check("rst irq", {31'd0, irq}, 32'd0);
    rd(2'b01, v);
    check("rst status in reset", v, 32'h3);
    rst = 1'b1;
    tick(2);
    rd(2'b01, v);  check("status after reset", v, 32'h3);
    rd(2'b11, v);  check("divisor after reset", v, DIV_DEFAULT);
    rd(2'b10, v);  check("ctrl after reset", v, 32'd0);
    rd(2'b00, v);  check("data after reset", v, 32'd0);

    // Divisor clamp and CTRL masking
    wr(2'b11, 32'd1);          rd(2'b11, v); check("div clamp 1", v, 32'd4);
    wr(2'b11, 32'd0);          rd(2'b11, v); check("div clamp 0", v, 32'd4);
    wr(2'b11, 32'hFFFF_0003);  rd(2'b11, v); check("div clamp hi", v, 32'd4);
    dv = 16'($urandom_range(4, 65535));
    wr(2'b11, {16'hABCD, dv}); rd(2'b11, v); check("div rand", v, {16'd0, dv});
    wr(2'b10, 32'hFFFF_FFFE);  rd(2'b10, v); check("ctrl mask", v, 32'h2);
    wr(2'b10, 32'd0);

    // Transmit
    tx_test(0, 8'hA5, 8'($urandom), 8'($urandom), 16, $urandom_range(4, 12));
    for (int it = 1; it < 3; it++)
      tx_test(it, 8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(8, 16), $urandom_range(4, 12));

    // Receive: directed cases
    wr(2'b11, 32'd16);
    m_ctrl = 2'b10;
    wr(2'b10, 32'h2);
    rx_byte("rx 3c", 8'h3C, 1'b1);
    w1c("rx clr valid", 32'h4);
    rx_byte("rx first", 8'($urandom), 1'b1);
    rx_byte("rx overrun", 8'($urandom), 1'b1);
    rx_byte("rx frame", 8'h55, 1'b0);
    w1c("rx clr all", 32'h1C);

    // Short low pulse must not start a byte
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(30);
    rd(2'b01, v); check("glitch status", v, m_status());

    // Receive: randomized
    for (int it = 0; it < 6; it++) begin
      m_ctrl = 2'($urandom);
      wr(2'b10, {30'd0, m_ctrl});
      if ($urandom_range(0, 1) == 1)
        w1c($sformatf("rnd%0d clr", it), {27'd0, 3'($urandom), 2'b11});
      rx_byte($sformatf("rnd%0d", it), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset in the middle of a frame
    wr(2'b11, 32'd16);
    wr(2'b10, 32'h1);
    wr(2'b00, 32'h5A);
    tick(20);
    check("pre-reset txd low", {31'd0, txd}, 32'd0);
    check("pre-reset irq", {31'd0, irq}, 32'd1);
    #2;
    rst  = 1'b0;
    addr = 2'b01;
    #1;
    check("async rst txd", {31'd0, txd}, 32'd1);
    check("async rst status", rd_data, 32'h3);
    check("async rst irq", {31'd0, irq}, 32'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rd(2'b11, v); check("async rst divisor", v, DIV_DEFAULT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart.md
# uart

Memory-mapped 8N1 serial port device attached to the system bridge as a peer of the timer, switch and LED devices. It takes the bridge's shared device address, write data and per-device write enable. It returns a 32-bit read word and one interrupt line for a spare `HWInt` bit. It serialises bytes written by the CPU onto `txd` and deserialises `rxd` into a one-byte receive buffer with status flags.

## Interface
Parameters:
- `DIV_DEFAULT`, 434: reset value of the divisor register, in clocks per bit (50 MHz / 115200).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; asynchronous, active-low.
- `addr`  in  [3:2]  register select from the bridge (`DEV_Addr`).
- `we`  in  1  write strobe from the bridge, valid for one cycle.
- `DEV_WD`  in  32  write data.
- `DEVUart_RD`  out  32  read data; combinational from `addr` and the registers.
- `IRQ`  out  1  level interrupt to the bridge.
- `rxd`  in  1  asynchronous serial input; idles high.
- `txd`  out  1  serial output; registered; idles high.

## Operation
Register map (`addr`):
- 00 DATA
  - Write: `DEV_WD[7:0]` goes to the TX holding register. Accepted only when `tx_ready`=1; otherwise ignored.
  - Read: `{24'b0, rx_data}`.
- 01 STATUS, read value `{27'b0, frame_err, overrun, rx_valid, tx_idle, tx_ready}`.
  - Writing 1 to bit 2, 3 or 4 clears that flag (write-1-to-clear). Bits 0 and 1 are read-only.
- 10 CTRL, bits [1:0] = `{rx_irq_en, tx_irq_en}`; other bits read 0.
- 11 DIVISOR, bits [15:0].
  - A written value below 4 is stored as 4.
  - Each engine latches the divisor at frame start; a write mid-frame affects the next frame only.

`IRQ` = (`tx_irq_en` & `tx_ready`) | (`rx_irq_en` & `rx_valid`).

TX FSM: IDLE, START, DATA, STOP.
- IDLE with holding register full → START. In the same transition the byte moves to the shift register, `tx_ready` returns to 1 and `txd` drives 0.
- START and STOP each last exactly DIV cycles, with `txd`=0 and 1 respectively.
- DATA sends 8 bits LSB first, DIV cycles each, using a 3-bit bit counter.
- STOP → START directly if the holding register is full (back-to-back frames); otherwise → IDLE.
- `tx_idle` = (state==IDLE) & `tx_ready`.

RX FSM: IDLE, START, DATA, STOP. It operates on `rxd` after a 2-flop synchroniser whose flops reset to 1.
- IDLE → START on a synchronised low.
- START waits DIV/2 (integer floor) cycles, then re-samples. If high, it is a glitch → IDLE. If low → DATA.
- DATA samples 8 bits LSB first, each DIV cycles after the previous sample.
- STOP samples after DIV cycles, then → IDLE:
  - Sample 0: set `frame_err` and discard the byte.
  - Sample 1 with `rx_valid`=0: write `rx_data` and set `rx_valid`.
  - Sample 1 with `rx_valid`=1: set `overrun`, discard the new byte, leave `rx_data` unchanged.

Simultaneous events:
- A W1C of `rx_valid` on the same cycle a good byte completes: the byte is stored, `rx_valid` stays 1, `overrun` is not set.
- A write to DATA on the same cycle the holding register empties into the shift register: the write is ignored. Software must poll `tx_ready`.

Reset (asynchronous, any time, including mid-frame):
- Both FSMs → IDLE; `txd`=1.
- `tx_ready`=1, `tx_idle`=1, `rx_valid`=0, `overrun`=0, `frame_err`=0, `rx_data`=0.
- CTRL=0, DIVISOR=`DIV_DEFAULT`.
- Resulting outputs: `IRQ`=0, and `DEVUart_RD` at `addr`=01 reads 0x3.

## Timing
- Register writes take effect at the rising edge where `we`=1. Reads reflect the new value in the following cycle.
- TX start latency:
  - DATA write at edge E0 → `tx_ready`=0 after E0.
  - If the engine is idle, `txd` falls at E1 and `tx_ready`=1 after E1.
  - Frame length is exactly 10·DIV cycles from E1 to the return to IDLE.
- RX latency:
  - The synchroniser adds 2 cycles.
  - `rx_valid` rises DIV/2 + 9·DIV + 2 cycles (±1) after the `rxd` falling edge of the start bit.
- `IRQ` follows the flag and enable registers combinationally, so it has no added latency beyond the flag update.
- Counters are 16 bits, count down from DIV−1 to 0, and reload on bit boundaries. There is no wrap condition beyond the reload.

## Test plan
- Reset check, no stimulus:
  - `txd`=1, `IRQ`=0.
  - STATUS reads 0x00000003, DIVISOR reads `DIV_DEFAULT`.
  - Assert `rst`=0 mid-frame → `txd`=1 and STATUS=0x3 immediately, with no clock edge needed.
- TX, DIVISOR=16, write DATA=0xA5:
  - `txd` shows 0, then 1,0,1,0,0,1,0,1, then 1.
  - Each bit lasts 16 cycles; the frame is 160 cycles.
  - A second write while `tx_ready`=1 follows back-to-back with no idle gap.
  - A third write while `tx_ready`=0 is ignored.
- RX, DIVISOR=16, drive 0x3C at 16 cycles/bit:
  - `rx_valid`=1 and DATA reads 0x3C.
  - With CTRL=0x2, `IRQ`=1.
  - Write STATUS=0x4 → `rx_valid`=0 and `IRQ`=0.
- Overrun and framing:
  - Send two bytes without clearing → `overrun`=1 and DATA still holds the first byte.
  - Send 0x55 with the stop bit held low → `frame_err`=1 and `rx_valid` unchanged.
- Glitch and clamp:
  - A 3-cycle low pulse on `rxd` → no `rx_valid`.
  - Write DIVISOR=1 → reads 4.
  - A DIVISOR write mid-TX-frame leaves the current frame's bit length unchanged.
